// File: rtl/multi_clock_divider.sv
// Bank of independent programmable clock dividers with a shared configuration write port.
// Every channel outputs a divided clock (square or pulse mode) and a terminal-count strobe.
module multi_clock_divider #(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned DIV_W    = 27,
  parameter int unsigned DEF_DIV  = 2,
  parameter bit          DEF_MODE = 1'b0,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic              cfg_err,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick
);

  logic [DIV_W-1:0] div_r [N_CH];
  logic [DIV_W-1:0] cnt_r [N_CH];
  logic [N_CH-1:0]  mode_r;

  logic             accept;
  logic             cfg_bad;
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  term;

  assign accept  = cfg_valid & cfg_ready;
  assign cfg_bad = 32'(cfg_ch) >= N_CH;

  always_comb begin
    wr_hit = '0;
    term   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      wr_hit[i] = accept && !cfg_bad && (32'(cfg_ch) == i);
      term[i]   = (cnt_r[i] == div_r[i] - DIV_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        div_r[i] <= DIV_W'(DEF_DIV);
        cnt_r[i] <= '0;
      end
      mode_r    <= {N_CH{DEF_MODE}};
      clk_out   <= '0;
      tick      <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= ~accept;
      cfg_err   <= accept & cfg_bad;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (wr_hit[i]) begin
          div_r[i]  <= cfg_div;
          mode_r[i] <= cfg_mode;
        end
        // A write or restart restarts the period from zero, so no partial pulse can escape.
        if (sync_restart || wr_hit[i] || div_r[i] == '0) begin
          cnt_r[i]   <= '0;
          tick[i]    <= 1'b0;
          clk_out[i] <= 1'b0;
        end else if (!ch_en[i]) begin
          tick[i] <= 1'b0;
          if (mode_r[i])
            clk_out[i] <= 1'b0;
        end else if (term[i]) begin
          cnt_r[i]   <= '0;
          tick[i]    <= 1'b1;
          clk_out[i] <= mode_r[i] ? 1'b1 : ~clk_out[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + DIV_W'(1);
          tick[i]  <= 1'b0;
          if (mode_r[i])
            clk_out[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Randomised and directed checks of multi_clock_divider against an arithmetic reference model
// that tracks enabled cycles since each channel's period start.
module tb_multi_clock_divider;
    localparam int N = 3;
    localparam int W = 27;

    logic          clk;
    logic          rst;
    logic [N-1:0]  ch_en;
    logic          sync_restart;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [W-1:0]  cfg_div;
    logic          cfg_mode;
    logic          cfg_err;
    logic [N-1:0]  clk_out;
    logic [N-1:0]  tick;

    multi_clock_divider #(.N_CH(N), .DIV_W(W), .DEF_DIV(2), .DEF_MODE(1'b0)) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .sync_restart(sync_restart),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
        .clk_out(clk_out), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: e counts enabled cycles since the period was (re)started.
    int unsigned m_div  [N];
    bit          m_mode [N];
    longint      m_e    [N];
    bit          m_tick [N];
    bit          m_clk  [N];
    bit          m_ready;
    bit          m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit acc, oob, wr;
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                m_div[c] = 2; m_mode[c] = 0; m_e[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
            end
            m_ready = 0;
            m_err   = 0;
        end else begin
            acc = cfg_valid && m_ready;
            oob = int'(cfg_ch) >= N;
            m_err   = acc && oob;
            m_ready = !acc;
            for (int c = 0; c < N; c++) begin
                wr = acc && !oob && (int'(cfg_ch) == c);
                if (wr) begin
                    m_div[c]  = int'(cfg_div);
                    m_mode[c] = cfg_mode;
                end
                if (sync_restart || wr || m_div[c] == 0) begin
                    m_e[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
                end else if (!ch_en[c]) begin
                    m_tick[c] = 0;
                    if (m_mode[c]) m_clk[c] = 0;
                end else begin
                    m_e[c]++;
                    m_tick[c] = (m_e[c] % m_div[c]) == 0;
                    m_clk[c]  = m_mode[c] ? m_tick[c] : bit'((m_e[c] / m_div[c]) % 2);
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        for (int c = 0; c < N; c++) begin
            chk($sformatf("tick[%0d]", c), 32'(tick[c]), 32'(m_tick[c]));
            chk($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(m_clk[c]));
        end
    endtask

    task automatic write(input int ch, input int div, input bit mode);
        cfg_valid = 1; cfg_ch = 2'(ch); cfg_div = W'(div); cfg_mode = mode;
        cycle();
        cfg_valid = 0;
    endtask

    logic [7:0] cap_clk, cap_tick;
    logic [9:0] cap_pulse;

    initial begin
        rst = 1; ch_en = '1; sync_restart = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0; cfg_mode = 0;
        repeat (3) cycle();
        chk("reset_ready", 32'(cfg_ready), 32'd0);
        chk("reset_clk_out", 32'(clk_out), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);

        // Defaults: div 2 square -> period 4, tick every 2 cycles.
        rst = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            cap_clk  = {cap_clk[6:0], clk_out[0]};
            cap_tick = {cap_tick[6:0], tick[0]};
        end
        chk("default_clk_pattern", 32'(cap_clk), 32'h66);
        chk("default_tick_pattern", 32'(cap_tick), 32'h55);
        chk("ready_after_reset", 32'(cfg_ready), 32'd1);

        // ch1 div 5 pulse mode: first pulse 5 cycles after apply.
        write(1, 5, 1);
        chk("ready_low_after_accept", 32'(cfg_ready), 32'd0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            cap_pulse = {cap_pulse[8:0], clk_out[1]};
        end
        chk("pulse_pattern", 32'(cap_pulse), 32'h021);

        // Out-of-range channel.
        write(3, 9, 1);
        chk("cfg_err_high", 32'(cfg_err), 32'd1);
        cycle();
        chk("cfg_err_low", 32'(cfg_err), 32'd0);

        // ch0 idle, then div 1.
        write(0, 0, 0);
        repeat (4) begin
            cycle();
            chk("idle_clk", 32'(clk_out[0]), 32'd0);
            chk("idle_tick", 32'(tick[0]), 32'd0);
        end
        write(0, 1, 0);
        repeat (5) begin
            cycle();
            chk("div1_tick", 32'(tick[0]), 32'd1);
        end

        // Freeze channel 2 for 7 cycles.
        write(2, 6, 0);
        repeat (4) cycle();
        ch_en = 3'b011;
        repeat (7) cycle();
        ch_en = 3'b111;
        repeat (14) cycle();

        // Sync restart then reset mid-period.
        sync_restart = 1;
        cycle();
        chk("restart_zero", 32'({clk_out, tick}), 32'd0);
        sync_restart = 0;
        repeat (3) cycle();
        rst = 1;
        cycle();
        chk("rst_mid_zero", 32'({clk_out, tick, cfg_ready}), 32'd0);
        rst = 0;

        for (int k = 0; k < 4000; k++) begin
            rst          = ($urandom_range(0, 299) == 0);
            sync_restart = ($urandom_range(0, 49) == 0);
            cfg_valid    = ($urandom_range(0, 7) == 0);
            cfg_ch       = 2'($urandom_range(0, 3));
            cfg_div      = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1)) : W'($urandom_range(2, 9));
            cfg_mode     = 1'($urandom_range(0, 1));
            for (int c = 0; c < N; c++) ch_en[c] = ($urandom_range(0, 7) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_clock_divider.md
MULTI_CLOCK_DIVIDER -- requirements
Module: multi_clock_divider

Interface
REQ-001 Parameter N_CH, default 3: number of independent divider channels; legal range 1..16.
REQ-002 Parameter DIV_W, default 27: divisor and counter width in bits.
REQ-003 Parameter DEF_DIV, default 2: divisor loaded into every channel at reset; DEF_DIV < 2^DIV_W.
REQ-004 Parameter DEF_MODE, default 0: mode loaded into every channel at reset; 0 = square, 1 = pulse.
REQ-005 Derived CH_W = max(1, ceil(log2(N_CH))).
REQ-006 clk  input  1  system clock (100 MHz); all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 ch_en  input  N_CH  per-channel count enable.
REQ-009 sync_restart  input  1  clears all channel counters and outputs for phase alignment.
REQ-010 cfg_valid  input  1  configuration write request.
REQ-011 cfg_ready  output  1  configuration write can be accepted.
REQ-012 cfg_ch  input  CH_W  target channel index.
REQ-013 cfg_div  input  DIV_W  new divisor.
REQ-014 cfg_mode  input  1  new mode.
REQ-015 cfg_err  output  1  one-cycle flag: accepted write had cfg_ch >= N_CH.
REQ-016 clk_out  output  N_CH  per-channel divided output.
REQ-017 tick  output  N_CH  per-channel one-cycle terminal-count strobe.

Function
REQ-018 Each channel i SHALL hold registers div[i], mode[i] and cnt[i] (DIV_W bits); all outputs SHALL be registered.
REQ-019 Counting: when ch_en[i]=1 and div[i]>=1, cnt[i] SHALL increment each cycle; when cnt[i]==div[i]-1, cnt[i] SHALL become 0 and tick[i] SHALL be 1 in the following cycle; otherwise tick[i]=0.
REQ-020 Square mode: clk_out[i] SHALL toggle at each terminal count, giving a period of 2*div[i] cycles at 50% duty.
REQ-021 Pulse mode: clk_out[i] SHALL equal tick[i], giving a 1-cycle pulse every div[i] cycles.
REQ-022 div[i]=1: tick[i] SHALL stay high continuously; square mode SHALL toggle every cycle.
REQ-023 div[i]=0: the channel SHALL be idle, with cnt[i]=0, tick[i]=0 and clk_out[i]=0.
REQ-024 ch_en[i]=0: cnt[i] and clk_out[i] SHALL hold their values, and tick[i] SHALL be 0.
REQ-025 Handshake: a write SHALL be accepted on a cycle with cfg_valid=1 and cfg_ready=1.
REQ-026 cfg_ready SHALL be 0 for exactly the one cycle after an acceptance, and 1 otherwise outside reset.
REQ-027 Accepted write to a valid channel: in the next cycle, div, mode and cnt of that channel SHALL equal cfg_div, cfg_mode and 0, with clk_out and tick of that channel equal to 0; other channels SHALL be unaffected.
REQ-028 Accepted write with cfg_ch >= N_CH: no state SHALL change, and cfg_err SHALL be 1 for one cycle.
REQ-029 A write and a terminal count on the same channel in the same cycle: the write SHALL win, with no tick and no toggle.
REQ-030 sync_restart=1: all cnt, clk_out and tick SHALL be 0 in the next cycle; div and mode SHALL be retained.
REQ-031 sync_restart SHALL take priority over a simultaneous configuration write, which SHALL still be accepted and applied.
REQ-032 A divisor change SHALL never produce a truncated pulse or a glitch on clk_out; the new period SHALL start from cnt=0.

Reset
REQ-033 While rst=1, in the cycle after: div=DEF_DIV, mode=DEF_MODE, cnt=0, clk_out=0, tick=0, cfg_err=0 and cfg_ready=0.
REQ-034 cfg_ready SHALL rise in the first cycle after rst deasserts.
REQ-035 rst SHALL override sync_restart and cfg writes; rst asserted mid-period SHALL discard all state.
REQ-036 A write whose acceptance coincides with rst=1 SHALL be lost.

Verification
REQ-037 Defaults (N_CH=3, DEF_DIV=2, mode square), ch_en=3'b111 -> all clk_out show period 4 cycles at 50% duty, with tick every 2 cycles.
REQ-038 Write ch1 div=5, mode=1 -> cfg_ready low for 1 cycle; clk_out[1] gives a 1-cycle pulse every 5 cycles, with the first pulse 5 enabled cycles after apply.
REQ-039 Write ch0 div=0, then div=1 -> ch0 is idle at 0, then tick[0] stays constantly high.
REQ-040 Write cfg_ch=3 with N_CH=3 -> cfg_err is high for exactly 1 cycle, and no channel changes.
REQ-041 ch_en[2] dropped for 7 cycles mid-period -> cnt[2] and clk_out[2] freeze, then resume; the period stretches by exactly 7 cycles.
REQ-042 Write on the terminal-count cycle, sync_restart pulsed, and rst mid-period -> no tick on the written channel; all outputs read 0 the next cycle; after reset the defaults are restored.
